// File: rtl/switch_event_decoder_pkg.sv
// Shared state encoding, default timing and output bundle for switch gesture decoding.
package switch_event_decoder_pkg;

  // Decoder FSM states, 3-bit encoding shared with other button consumers
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_PRESSED2  = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  // Default timing at 25 MHz: 1 s long press, 250 ms double-click gap
  localparam int unsigned c_DEF_LONG_PRESS_CYCLES = 32'd25000000;
  localparam int unsigned c_DEF_DOUBLE_GAP_CYCLES = 32'd6250000;

  // Registered output bundle
  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic double_click;
    logic long_press;
    logic held;
  } events_t;

  // Larger of two cycle limits, used to size the shared counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_event_decoder_edge_detect.sv
// Rise/fall detector off a single history register.
module edge_detect (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise,
  output logic o_Fall
);

  logic r_Sig_Prev;

  // Previous-cycle level; cleared so a level already high at reset exit reads as a rise
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Sig_Prev <= 1'b0;
    else       r_Sig_Prev <= i_Sig;
  end

  assign o_Rise = i_Sig & ~r_Sig_Prev;
  assign o_Fall = ~i_Sig & r_Sig_Prev;

endmodule

// File: rtl/switch_event_decoder.sv
// Turns a debounced switch level into one-cycle gesture pulses plus a held level.
module switch_event_decoder
  import switch_event_decoder_pkg::*;
#(
  parameter int unsigned c_LONG_PRESS_CYCLES = c_DEF_LONG_PRESS_CYCLES,
  parameter int unsigned c_DOUBLE_GAP_CYCLES = c_DEF_DOUBLE_GAP_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Click,
  output logic o_Double_Click,
  output logic o_Long_Press,
  output logic o_Held
);

  localparam int unsigned c_CNT_W =
    $clog2(max_u(c_LONG_PRESS_CYCLES, c_DOUBLE_GAP_CYCLES) + 1);

  localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(c_LONG_PRESS_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(c_DOUBLE_GAP_CYCLES - 1);

  state_t               r_State;
  state_t               w_State_Next;
  logic [c_CNT_W-1:0]   r_Cnt;
  logic [c_CNT_W-1:0]   w_Cnt_Next;
  events_t              r_Evt;
  events_t              w_Evt_Next;
  logic                 w_Rise;
  logic                 w_Fall;

  edge_detect u_edge_detect (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (i_Switch),
    .o_Rise (w_Rise),
    .o_Fall (w_Fall)
  );

  // State, counter and output registers; reset abandons any gesture in flight
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= S_IDLE;
      r_Cnt   <= '0;
      r_Evt   <= '0;
    end else begin
      r_State <= w_State_Next;
      r_Cnt   <= w_Cnt_Next;
      r_Evt   <= w_Evt_Next;
    end
  end

  // Next state; counter restarts on every state change and runs only while timing
  always_comb begin
    w_State_Next = r_State;
    case (r_State)
      S_IDLE:      if (w_Rise) w_State_Next = S_PRESSED1;
      S_PRESSED1: begin
        if (w_Fall)                    w_State_Next = S_WAIT_GAP;
        else if (r_Cnt == c_LONG_LAST) w_State_Next = S_LONG_HELD;
      end
      S_WAIT_GAP: begin
        if (w_Rise)                   w_State_Next = S_PRESSED2;
        else if (r_Cnt == c_GAP_LAST) w_State_Next = S_IDLE;
      end
      S_PRESSED2:  if (w_Fall) w_State_Next = S_IDLE;
      S_LONG_HELD: if (w_Fall) w_State_Next = S_IDLE;
      default:     w_State_Next = S_IDLE;
    endcase

    w_Cnt_Next = '0;
    if ((w_State_Next == r_State) &&
        ((r_State == S_PRESSED1) || (r_State == S_WAIT_GAP))) begin
      w_Cnt_Next = r_Cnt + c_CNT_W'(1);
    end
  end

  // Gesture decisions; edges take priority over timer thresholds
  always_comb begin
    w_Evt_Next       = '0;
    w_Evt_Next.press = w_Rise;
    w_Evt_Next.rel   = w_Fall;
    case (r_State)
      S_PRESSED1: w_Evt_Next.long_press   = ~w_Fall & (r_Cnt == c_LONG_LAST);
      S_WAIT_GAP: w_Evt_Next.click        = ~w_Rise & (r_Cnt == c_GAP_LAST);
      S_PRESSED2: w_Evt_Next.double_click = w_Fall;
      default:    ;
    endcase
    w_Evt_Next.held = (w_State_Next == S_LONG_HELD);
  end

  assign o_Press        = r_Evt.press;
  assign o_Release      = r_Evt.rel;
  assign o_Click        = r_Evt.click;
  assign o_Double_Click = r_Evt.double_click;
  assign o_Long_Press   = r_Evt.long_press;
  assign o_Held         = r_Evt.held;

endmodule

// File: tb/tb_switch_event_decoder.sv
// Scoreboard bench: scenarios push expected per-cycle output events, a monitor pops and compares.
module tb_switch_event_decoder;

  localparam logic [6:0] E_PRESS = 7'h01;
  localparam logic [6:0] E_REL   = 7'h02;
  localparam logic [6:0] E_CLICK = 7'h04;
  localparam logic [6:0] E_DBL   = 7'h08;
  localparam logic [6:0] E_LONG  = 7'h10;
  localparam logic [6:0] E_HRISE = 7'h20;
  localparam logic [6:0] E_HFALL = 7'h40;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sw;
  logic o_press, o_release, o_click, o_double, o_long, o_held;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   b;

  switch_event_decoder #(
    .c_LONG_PRESS_CYCLES (20),
    .c_DOUBLE_GAP_CYCLES (10)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Switch       (sw),
    .o_Press        (o_press),
    .o_Release      (o_release),
    .o_Click        (o_click),
    .o_Double_Click (o_double),
    .o_Long_Press   (o_long),
    .o_Held         (o_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  // Hold the switch at v for n sampling edges; returns at a falling edge
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sw = v;
      @(negedge clk);
    end
  endtask

  // Monitor: observed event vector per cycle against the scoreboard head
  initial begin : monitor
    logic       held_prev;
    logic [6:0] vec;
    exp_t       e;
    held_prev = 1'b0;
    forever begin
      @(negedge clk);
      vec = {~o_held & held_prev, o_held & ~held_prev, o_long, o_double,
             o_click, o_release, o_press};
      held_prev = o_held;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        $display("FAIL missed_event cyc=%0d: got nothing, required vec=%b", e.cyc, e.vec);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        checks++;
        if (vec == e.vec) passes++;
        else $display("FAIL event cyc=%0d: got vec=%b, required vec=%b", cyc, vec, e.vec);
      end else if (vec != 7'd0) begin
        checks++;
        $display("FAIL unexpected_event cyc=%0d: got vec=%b, required vec=0000000", cyc, vec);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    sw  = 1'b1;
    repeat (3) @(negedge clk);

    // Outputs quiet while held in reset
    checks++;
    if ({o_press, o_release, o_click, o_double, o_long, o_held} == 6'd0) passes++;
    else $display("FAIL reset_outputs: got %b, required 000000",
                  {o_press, o_release, o_click, o_double, o_long, o_held});

    // Switch already high at reset exit -> press on first active cycle
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 3, E_REL);
    expect_ev(b + 13, E_CLICK);
    rst = 1'b0;
    drive(1'b1, 3);
    drive(1'b0, 15);

    // Single click
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 5, E_REL);
    expect_ev(b + 15, E_CLICK);
    drive(1'b1, 5);
    drive(1'b0, 14);

    // Double click
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 5, E_REL);
    expect_ev(b + 9, E_PRESS);
    expect_ev(b + 14, E_REL | E_DBL);
    drive(1'b1, 5);
    drive(1'b0, 4);
    drive(1'b1, 5);
    drive(1'b0, 14);

    // Long press held 30 cycles
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 20, E_LONG | E_HRISE);
    expect_ev(b + 30, E_REL | E_HFALL);
    drive(1'b1, 30);
    drive(1'b0, 14);

    // Release at cnt=19: fall beats threshold, click path
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 20, E_REL);
    expect_ev(b + 30, E_CLICK);
    drive(1'b1, 20);
    drive(1'b0, 14);

    // One cycle longer reaches the long press
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 20, E_LONG | E_HRISE);
    expect_ev(b + 21, E_REL | E_HFALL);
    drive(1'b1, 21);
    drive(1'b0, 14);

    // Second press at gap cnt=9: rise beats expiry, double click
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 3, E_REL);
    expect_ev(b + 13, E_PRESS);
    expect_ev(b + 15, E_REL | E_DBL);
    drive(1'b1, 3);
    drive(1'b0, 10);
    drive(1'b1, 2);
    drive(1'b0, 14);

    // Second press one cycle late: click, then a fresh gesture
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 3, E_REL);
    expect_ev(b + 13, E_CLICK);
    expect_ev(b + 14, E_PRESS);
    expect_ev(b + 16, E_REL);
    expect_ev(b + 26, E_CLICK);
    drive(1'b1, 3);
    drive(1'b0, 11);
    drive(1'b1, 2);
    drive(1'b0, 14);

    // Reset pulse inside the gap abandons the click
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 4, E_REL);
    drive(1'b1, 4);
    drive(1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 15);

    // Next press decodes cleanly after the reset
    b = cyc + 1;
    expect_ev(b, E_PRESS);
    expect_ev(b + 5, E_REL);
    expect_ev(b + 15, E_CLICK);
    drive(1'b1, 5);
    drive(1'b0, 16);

    // Every expected event must have been consumed
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending events, required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
